// File: rtl/my_filter_pkg.sv
// rtl/my_filter_pkg.sv - shared types and width helpers for the filter family
//
// Purpose: FIR state encoding plus helpers that derive the accumulator width
//          and the rounding constant from the sample/coefficient widths.
// Ports:   none (package).
package my_filter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        MAC1,
        MAC2,
        ROUND,
        OUT
    } fir_state_t;

    // Two guard bits above one product: three worst-case products cannot overflow.
    function automatic int fir_acc_w(input int din_w, input int coeff_w);
        return din_w + coeff_w + 2;
    endfunction

    // Half an LSB of the output scale; zero when there are no fractional bits.
    function automatic longint fir_round_const(input int frac);
        if (frac > 0) begin
            return 64'sd1 <<< (frac - 1);
        end
        return 64'sd0;
    endfunction

    localparam int FIR_ACC_W_DEFAULT = fir_acc_w(16, 18);
    localparam longint FIR_RND_DEFAULT = fir_round_const(14);

endpackage

// File: rtl/my_round_sat.sv
// rtl/my_round_sat.sv - round-half-up, arithmetic shift and saturate to DOUT_W
//
// Purpose: combinational output scaler: r = (acc + 2^(FRAC-1)) >>> FRAC,
//          clamped to the signed DOUT_W range.
// Ports:   i_acc  - signed accumulator (ACC_W bits)
//          o_dout - rounded, saturated result (DOUT_W bits)
//          o_ovf  - high when r was outside the DOUT_W range
module my_round_sat
    import my_filter_pkg::*;
#(
    parameter int ACC_W  = 36,
    parameter int FRAC   = 14,
    parameter int DOUT_W = 16
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [DOUT_W-1:0] o_dout,
    output logic                     o_ovf
);

    // One extra bit so adding the rounding constant to a near-max acc cannot wrap.
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] RND  = SUM_W'(fir_round_const(FRAC));
    localparam logic signed [SUM_W-1:0] MAXV = {{(SUM_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MINV = {{(SUM_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_r;

    assign w_sum = {i_acc[ACC_W-1], i_acc} + RND;
    assign w_r   = w_sum >>> FRAC;

    always_comb begin
        o_ovf  = 1'b0;
        o_dout = w_r[DOUT_W-1:0];
        if (w_r > MAXV) begin
            o_ovf  = 1'b1;
            o_dout = MAXV[DOUT_W-1:0];
        end else if (w_r < MINV) begin
            o_ovf  = 1'b1;
            o_dout = MINV[DOUT_W-1:0];
        end
    end

endmodule

// File: rtl/my_iir_whitening_fir.sv
// rtl/my_iir_whitening_fir.sv - 3-tap FIR with one shared multiplier
//
// Purpose: e[n] = sat(round((C0*x[n] + C1*x[n-1] + C2*x[n-2]) / 2^FRAC)),
//          one sample per 6 clocks, valid/ready on input and output.
// Ports:   clk, rst        - clock, synchronous active-high reset
//          din_valid/ready - input handshake, din signed DIN_W
//          dout_valid/ready- output handshake, dout signed DOUT_W
//          sat_flag        - current dout was saturated (qualified by dout_valid)
//          busy            - FSM not in IDLE
module my_iir_whitening_fir
    import my_filter_pkg::*;
#(
    parameter int DIN_W    = 16,
    parameter int DOUT_W   = 16,
    parameter int COEFF_W  = 18,
    parameter int FRAC     = 14,
    parameter int COEFF_C0 = 16384,
    parameter int COEFF_C1 = -32768,
    parameter int COEFF_C2 = 16384
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic signed [DIN_W-1:0]  din,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     sat_flag,
    output logic                     busy
);

    localparam int ACC_W  = fir_acc_w(DIN_W, COEFF_W);
    localparam int PROD_W = DIN_W + COEFF_W;

    localparam logic signed [COEFF_W-1:0] C0 = COEFF_W'(COEFF_C0);
    localparam logic signed [COEFF_W-1:0] C1 = COEFF_W'(COEFF_C1);
    localparam logic signed [COEFF_W-1:0] C2 = COEFF_W'(COEFF_C2);

    fir_state_t r_state;
    fir_state_t w_next;

    logic signed [DIN_W-1:0]   r_x0;
    logic signed [DIN_W-1:0]   r_x1;
    logic signed [DIN_W-1:0]   r_x2;
    logic signed [ACC_W-1:0]   r_acc;
    logic [1:0]                r_tap;
    logic signed [DOUT_W-1:0]  r_dout;
    logic                      r_dout_valid;
    logic                      r_sat;

    logic signed [DIN_W-1:0]   w_x_sel;
    logic signed [COEFF_W-1:0] w_c_sel;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [DOUT_W-1:0]  w_rs_dout;
    logic                      w_rs_ovf;

    // The tap index steers both operands of the single multiplier.
    always_comb begin
        w_x_sel = '0;
        w_c_sel = '0;
        case (r_tap)
            2'd0: begin w_x_sel = r_x0; w_c_sel = C0; end
            2'd1: begin w_x_sel = r_x1; w_c_sel = C1; end
            2'd2: begin w_x_sel = r_x2; w_c_sel = C2; end
            default: begin w_x_sel = '0; w_c_sel = '0; end
        endcase
    end

    assign w_prod     = w_x_sel * w_c_sel;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    my_round_sat #(
        .ACC_W  (ACC_W),
        .FRAC   (FRAC),
        .DOUT_W (DOUT_W)
    ) u_round_sat (
        .i_acc  (r_acc),
        .o_dout (w_rs_dout),
        .o_ovf  (w_rs_ovf)
    );

    always_comb begin
        w_next    = r_state;
        din_ready = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                din_ready = !rst;
                if (din_valid) w_next = MAC0;
            end
            MAC0:  w_next = MAC1;
            MAC1:  w_next = MAC2;
            MAC2:  w_next = ROUND;
            ROUND: w_next = OUT;
            OUT:   if (dout_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_x0         <= '0;
            r_x1         <= '0;
            r_x2         <= '0;
            r_acc        <= '0;
            r_tap        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (din_valid) begin
                        r_x0  <= din;
                        r_x1  <= r_x0;
                        r_x2  <= r_x1;
                        r_acc <= '0;
                        r_tap <= 2'd0;
                    end
                end
                MAC0, MAC1, MAC2: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_tap <= r_tap + 2'd1;
                end
                ROUND: begin
                    r_dout       <= w_rs_dout;
                    r_sat        <= w_rs_ovf;
                    r_dout_valid <= 1'b1;
                    r_tap        <= 2'd0;
                end
                OUT: begin
                    // dout keeps its last value after the transfer.
                    if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_sat        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign sat_flag   = r_sat;

endmodule

// File: tb/tb_my_iir_whitening_fir.sv
// tb/tb_my_iir_whitening_fir.sv - directed self-checking bench for my_iir_whitening_fir
module tb_my_iir_whitening_fir;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               din_valid = 1'b0;
    logic signed [15:0] din = '0;
    logic               dout_ready = 1'b1;

    logic               din_ready_a, dout_valid_a, sat_a, busy_a;
    logic signed [15:0] dout_a;
    logic               din_ready_b, dout_valid_b, sat_b, busy_b;
    logic signed [15:0] dout_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    my_iir_whitening_fir u_dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready_a),
        .din        (din),
        .dout_valid (dout_valid_a),
        .dout_ready (dout_ready),
        .dout       (dout_a),
        .sat_flag   (sat_a),
        .busy       (busy_a)
    );

    my_iir_whitening_fir #(
        .FRAC     (1),
        .COEFF_C0 (1),
        .COEFF_C1 (0),
        .COEFF_C2 (0)
    ) u_rnd (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready_b),
        .din        (din),
        .dout_valid (dout_valid_b),
        .dout_ready (dout_ready),
        .dout       (dout_b),
        .sat_flag   (sat_b),
        .busy       (busy_b)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one sample, returns the observed output and accept-to-valid latency.
    // Returns at the negedge where dout_valid is first seen.
    task automatic do_sample(input logic signed [15:0] v, input bit sel,
                             output logic signed [15:0] o_d, output logic o_s,
                             output int lat);
        int guard;
        o_d = 'x;
        o_s = 1'bx;
        lat = -1;
        @(negedge clk);
        guard = 0;
        while (!din_ready_a && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!din_ready_a) begin
            n_checks++;
            $display("FAIL accept_timeout din_ready=%0b required 1", din_ready_a);
            return;
        end
        din_valid = 1'b1;
        din = v;
        @(posedge clk);
        lat = 0;
        forever begin
            @(negedge clk);
            din_valid = 1'b0;
            if ((sel ? dout_valid_b : dout_valid_a) || lat >= 30) break;
            @(posedge clk);
            lat++;
        end
        if (!(sel ? dout_valid_b : dout_valid_a)) begin
            n_checks++;
            $display("FAIL output_timeout dout_valid=0 required 1");
            lat = -1;
            return;
        end
        o_d = sel ? dout_b : dout_a;
        o_s = sel ? sat_b : sat_a;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({din_ready_a, dout_valid_a, sat_a, busy_a} !== 4'b0000 || dout_a !== 16'sd0)
            $display("FAIL reset_outputs ready/valid/sat/busy=%b dout=%0d required 0000/0",
                     {din_ready_a, dout_valid_a, sat_a, busy_a}, dout_a);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (din_ready_a !== 1'b1)
            $display("FAIL reset_release_ready din_ready=%0b required 1", din_ready_a);
        else n_pass++;
    endtask

    task automatic test_impulse();
        logic signed [15:0] vin [4] = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] exp [4] = '{16'sd1000, -16'sd2000, 16'sd1000, 16'sd0};
        logic signed [15:0] d;
        logic s;
        int lat;
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_sample(vin[i], 1'b0, d, s, lat);
            n_checks++;
            if (d !== exp[i]) $display("FAIL impulse_dout[%0d] got %0d required %0d", i, d, exp[i]);
            else n_pass++;
            n_checks++;
            if (s !== 1'b0) $display("FAIL impulse_sat[%0d] got %0b required 0", i, s);
            else n_pass++;
            n_checks++;
            if (lat != 4) $display("FAIL impulse_latency[%0d] got %0d required 4", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_ramp();
        logic signed [15:0] vin [5] = '{16'sd0, 16'sd100, 16'sd200, 16'sd300, 16'sd400};
        logic signed [15:0] exp [5] = '{16'sd0, 16'sd100, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] d;
        logic s;
        int lat;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_sample(vin[i], 1'b0, d, s, lat);
            n_checks++;
            if (d !== exp[i]) $display("FAIL ramp_dout[%0d] got %0d required %0d", i, d, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] vin [3] = '{16'sd30000, -16'sd30000, 16'sd0};
        logic signed [15:0] exp [3] = '{16'sd30000, -16'sd32768, 16'sd32767};
        logic               exs [3] = '{1'b0, 1'b1, 1'b1};
        logic signed [15:0] d;
        logic s;
        int lat;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_sample(vin[i], 1'b0, d, s, lat);
            n_checks++;
            if (d !== exp[i]) $display("FAIL sat_dout[%0d] got %0d required %0d", i, d, exp[i]);
            else n_pass++;
            n_checks++;
            if (s !== exs[i]) $display("FAIL sat_flag[%0d] got %0b required %0b", i, s, exs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] d;
        logic s;
        int lat;
        int bad;
        int guard;
        do_reset();
        dout_ready = 1'b0;
        do_sample(16'sd500, 1'b0, d, s, lat);
        n_checks++;
        if (d !== 16'sd500) $display("FAIL bp_first_dout got %0d required 500", d);
        else n_pass++;
        din_valid = 1'b1;
        din = 16'sd777;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dout_a !== 16'sd500 || sat_a !== 1'b0 || dout_valid_a !== 1'b1 || din_ready_a !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold unstable cycles=%0d required 0", bad);
        else n_pass++;
        dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (din_ready_a !== 1'b1 || busy_a !== 1'b0 || dout_valid_a !== 1'b0)
            $display("FAIL bp_release ready/busy/valid=%b required 100",
                     {din_ready_a, busy_a, dout_valid_a});
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1) $display("FAIL bp_accept busy=%0b required 1", busy_a);
        else n_pass++;
        guard = 0;
        while (!dout_valid_a && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (dout_valid_a !== 1'b1 || dout_a !== -16'sd223)
            $display("FAIL bp_second_dout got %0d valid=%0b required -223 valid=1", dout_a, dout_valid_a);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_rounding();
        logic signed [15:0] d;
        logic s;
        int lat;
        do_reset();
        do_sample(16'sd3, 1'b1, d, s, lat);
        n_checks++;
        if (d !== 16'sd2 || s !== 1'b0) $display("FAIL round_pos got %0d sat=%0b required 2 sat=0", d, s);
        else n_pass++;
        do_sample(-16'sd3, 1'b1, d, s, lat);
        n_checks++;
        if (d !== -16'sd1 || s !== 1'b0) $display("FAIL round_neg got %0d sat=%0b required -1 sat=0", d, s);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] vin [3] = '{16'sd1000, 16'sd0, 16'sd0};
        logic signed [15:0] exp [3] = '{16'sd1000, -16'sd2000, 16'sd1000};
        logic signed [15:0] d;
        logic s;
        int lat;
        int seen;
        do_reset();
        do_sample(16'sd5000, 1'b0, d, s, lat);
        // Prime nonzero history, then start a sample and abort it in MAC1.
        @(negedge clk);
        din_valid = 1'b1;
        din = 16'sd7000;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || dout_valid_a !== 1'b0 || din_ready_a !== 1'b1)
            $display("FAIL mid_reset busy/valid/ready=%b required 001",
                     {busy_a, dout_valid_a, din_ready_a});
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dout_valid_a) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL mid_reset_no_output valid_cycles=%0d required 0", seen);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            do_sample(vin[i], 1'b0, d, s, lat);
            n_checks++;
            if (d !== exp[i]) $display("FAIL mid_reset_impulse[%0d] got %0d required %0d", i, d, exp[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_ramp();
        test_saturation();
        test_backpressure();
        test_rounding();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
